// File: rtl/slot_game_ctrl.sv
// -----------------------------------------------------------------------------
// slot_game_ctrl
//
// Game sequencer for the three-reel slot machine. Holds the credit balance,
// starts all three LFSR reels on an accepted spin, stops them one at a time
// (player stop button, or timeout when SLOT_AUTO_STOP_EN is defined), latches
// each reel's value on the very edge its run bit drops, scores the held values
// and pays out.
//
// Optional feature macro: SLOT_AUTO_STOP_EN
//   defined   : a SPIN idle counter stops the next reel after AUTO_STOP_CYC
//               cycles without a stop request.
//   undefined : reels stop only on stop_btn; SPIN may last indefinitely.
//
// Ports
//   clock                    in   system clock, rising edge
//   reset                    in   synchronous, active-high, overrides all
//   coin                     in   one-cycle pulse, adds one credit
//   spin_btn                 in   one-cycle pulse, request a new game
//   stop_btn                 in   one-cycle pulse, stop next running reel
//   reel0_val..reel2_val     in   [3:0] reel shift_reg outputs
//   reel_run                 out  [2:0] reel running enables (bit k = reel k)
//   held0..held2             out  [3:0] reel values latched at stop
//   credits                  out  [CREDIT_W-1:0] credit balance (saturating)
//   payout                   out  [7:0] award of last game, cleared on spin
//   win                      out  one-cycle pulse when payout != 0
//   busy                     out  high in SPIN and EVAL
// -----------------------------------------------------------------------------
module slot_game_ctrl #(
  parameter int CREDIT_W      = 8,
  parameter int PAYOUT_TRIPLE = 10,
  parameter int PAYOUT_PAIR   = 2,
  parameter int AUTO_STOP_CYC = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin,
  input  logic                spin_btn,
  input  logic                stop_btn,
  input  logic [3:0]          reel0_val,
  input  logic [3:0]          reel1_val,
  input  logic [3:0]          reel2_val,
  output logic [2:0]          reel_run,
  output logic [3:0]          held0,
  output logic [3:0]          held1,
  output logic [3:0]          held2,
  output logic [CREDIT_W-1:0] credits,
  output logic [7:0]          payout,
  output logic                win,
  output logic                busy
);

  // Extra headroom bits so coin + payout on top of a full balance cannot wrap
  // before the clamp.
  localparam int SUM_W = CREDIT_W + 4;
  localparam logic [SUM_W-1:0] CRED_MAX = SUM_W'({CREDIT_W{1'b1}});
  // Value a stopped reel reloads; also the held reset value.
  localparam logic [3:0] REEL_IDLE = 4'b0100;

  typedef enum logic [1:0] {ST_IDLE, ST_SPIN, ST_EVAL} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [2:0]          run_q, run_d;
  logic [3:0]          held0_q, held0_d;
  logic [3:0]          held1_q, held1_d;
  logic [3:0]          held2_q, held2_d;
  logic [7:0]          payout_q, payout_d;
  logic                win_q, win_d;
  logic [1:0]          idx_q, idx_d;

  logic                spin_acc;
  logic                stop_evt;
  logic                timeout;
  logic [7:0]          score_res;
  logic [SUM_W-1:0]    cred_sum;

  function automatic logic [CREDIT_W-1:0] sat_credits(input logic [SUM_W-1:0] s);
    if (s > CRED_MAX) return CRED_MAX[CREDIT_W-1:0];
    return s[CREDIT_W-1:0];
  endfunction

  function automatic logic [7:0] score(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c);
    if ((a == b) && (b == c))                return 8'(PAYOUT_TRIPLE);
    if ((a == b) || (a == c) || (b == c))   return 8'(PAYOUT_PAIR);
    return 8'd0;
  endfunction

  // Credits are tested before this edge's coin, so coin+spin at zero balance
  // does not start a game.
  assign spin_acc  = (state_q == ST_IDLE) && spin_btn && (credits_q != '0);
  // Button and timeout on the same edge still stop only one reel.
  assign stop_evt  = (state_q == ST_SPIN) && (stop_btn || timeout);
  assign score_res = score(held0_q, held1_q, held2_q);

`ifdef SLOT_AUTO_STOP_EN
  localparam int CNT_W = (AUTO_STOP_CYC > 2) ? $clog2(AUTO_STOP_CYC) : 1;

  logic [CNT_W-1:0] tmo_q, tmo_d;

  assign timeout = (state_q == ST_SPIN) && (tmo_q == CNT_W'(AUTO_STOP_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (spin_acc || stop_evt) begin
      tmo_d = '0;
    end else if (state_q == ST_SPIN) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Single saturation over every contribution of this edge.
  always_comb begin
    cred_sum = SUM_W'(credits_q) + SUM_W'(coin);
    if (state_q == ST_EVAL) cred_sum = cred_sum + SUM_W'(score_res);
    if (spin_acc)           cred_sum = cred_sum - SUM_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    credits_d = sat_credits(cred_sum);
    run_d     = run_q;
    held0_d   = held0_q;
    held1_d   = held1_q;
    held2_d   = held2_q;
    payout_d  = payout_q;
    win_d     = 1'b0;
    idx_d     = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (spin_acc) begin
          state_d  = ST_SPIN;
          run_d    = 3'b111;
          payout_d = 8'd0;
          idx_d    = 2'd0;
        end
      end
      ST_SPIN: begin
        // Capture and run-drop share the edge: the reel reloads its idle
        // value on the following edge.
        if (stop_evt) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: begin
              held0_d  = reel0_val;
              run_d[0] = 1'b0;
            end
            2'd1: begin
              held1_d  = reel1_val;
              run_d[1] = 1'b0;
            end
            default: begin
              held2_d  = reel2_val;
              run_d[2] = 1'b0;
              state_d  = ST_EVAL;
            end
          endcase
        end
      end
      ST_EVAL: begin
        payout_d = score_res;
        win_d    = (score_res != 8'd0);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      credits_q <= '0;
      run_q     <= 3'b000;
      held0_q   <= REEL_IDLE;
      held1_q   <= REEL_IDLE;
      held2_q   <= REEL_IDLE;
      payout_q  <= 8'd0;
      win_q     <= 1'b0;
      idx_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      run_q     <= run_d;
      held0_q   <= held0_d;
      held1_q   <= held1_d;
      held2_q   <= held2_d;
      payout_q  <= payout_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
    end
  end

  assign reel_run = run_q;
  assign held0    = held0_q;
  assign held1    = held1_q;
  assign held2    = held2_q;
  assign credits  = credits_q;
  assign payout   = payout_q;
  assign win      = win_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_slot_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slot_game_ctrl
//
// Directed bench for slot_game_ctrl with default parameters. Reel outputs are
// driven directly so each stop captures a known value. Inputs change 1 time
// unit after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_slot_game_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin = 1'b0;
  logic       spin_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [3:0] reel0_val = 4'b0100;
  logic [3:0] reel1_val = 4'b0100;
  logic [3:0] reel2_val = 4'b0100;
  logic [2:0] reel_run;
  logic [3:0] held0, held1, held2;
  logic [7:0] credits;
  logic [7:0] payout;
  logic       win;
  logic       busy;

  int checks = 0;
  int failures = 0;

  slot_game_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .coin      (coin),
    .spin_btn  (spin_btn),
    .stop_btn  (stop_btn),
    .reel0_val (reel0_val),
    .reel1_val (reel1_val),
    .reel2_val (reel2_val),
    .reel_run  (reel_run),
    .held0     (held0),
    .held1     (held1),
    .held2     (held2),
    .credits   (credits),
    .payout    (payout),
    .win       (win),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_reels(input logic [3:0] v);
    reel0_val = v;
    reel1_val = v;
    reel2_val = v;
  endtask

  task automatic stop_with(input logic [3:0] v);
    set_reels(v);
    stop_btn = 1'b1;
    tick();
    stop_btn = 1'b0;
    set_reels(4'b0100);
  endtask

  task automatic do_spin();
    spin_btn = 1'b1;
    tick();
    spin_btn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (credits !== 8'd0) begin failures++; $display("FAIL reset_credits got=%0d exp=0", credits); end
    checks++; if (reel_run !== 3'b000) begin failures++; $display("FAIL reset_run got=%b exp=000", reel_run); end
    checks++; if ({held0, held1, held2} !== 12'h444) begin failures++; $display("FAIL reset_held got=%h exp=444", {held0, held1, held2}); end
    checks++; if ({payout, win, busy} !== 10'd0) begin failures++; $display("FAIL reset_out payout=%0d win=%b busy=%b exp 0/0/0", payout, win, busy); end
  endtask

  task automatic test_triple();
    repeat (3) begin coin = 1'b1; tick(); coin = 1'b0; end
    checks++; if (credits !== 8'd3) begin failures++; $display("FAIL coin3 got=%0d exp=3", credits); end
    do_spin();
    checks++; if ({credits, reel_run, busy} !== {8'd2, 3'b111, 1'b1}) begin failures++; $display("FAIL spin_start credits=%0d run=%b busy=%b exp 2/111/1", credits, reel_run, busy); end
    do_spin();
    checks++; if ({credits, reel_run} !== {8'd2, 3'b111}) begin failures++; $display("FAIL spin_in_spin credits=%0d run=%b exp 2/111", credits, reel_run); end
    stop_with(4'd5);
    checks++; if ({held0, reel_run} !== {4'd5, 3'b110}) begin failures++; $display("FAIL stop0 held0=%0d run=%b exp 5/110", held0, reel_run); end
    stop_with(4'd5);
    stop_with(4'd5);
    checks++; if ({reel_run, busy, win, credits} !== {3'b000, 1'b1, 1'b0, 8'd2}) begin failures++; $display("FAIL eval_cycle run=%b busy=%b win=%b credits=%0d exp 000/1/0/2", reel_run, busy, win, credits); end
    tick();
    checks++; if ({credits, payout, win, busy} !== {8'd12, 8'd10, 1'b1, 1'b0}) begin failures++; $display("FAIL triple credits=%0d payout=%0d win=%b busy=%b exp 12/10/1/0", credits, payout, win, busy); end
    checks++; if ({held0, held1, held2} !== 12'h555) begin failures++; $display("FAIL triple_held got=%h exp=555", {held0, held1, held2}); end
    tick();
    checks++; if ({win, payout} !== {1'b0, 8'd10}) begin failures++; $display("FAIL win_pulse win=%b payout=%0d exp 0/10", win, payout); end
  endtask

  task automatic test_back_to_back();
    do_spin();
    checks++; if ({credits, payout} !== {8'd11, 8'd0}) begin failures++; $display("FAIL b2b_spin credits=%0d payout=%0d exp 11/0", credits, payout); end
    reel0_val = 4'd3; reel1_val = 4'd9; reel2_val = 4'd3;
    stop_btn = 1'b1;
    tick();
    checks++; if (reel_run !== 3'b110) begin failures++; $display("FAIL b2b_stop1 run=%b exp=110", reel_run); end
    tick();
    checks++; if (reel_run !== 3'b100) begin failures++; $display("FAIL b2b_stop2 run=%b exp=100", reel_run); end
    tick();
    stop_btn = 1'b0;
    set_reels(4'b0100);
    checks++; if ({reel_run, held0, held1, held2} !== {3'b000, 12'h393}) begin failures++; $display("FAIL b2b_held run=%b held=%h exp 000/393", reel_run, {held0, held1, held2}); end
    coin = 1'b1;
    tick();
    coin = 1'b0;
    checks++; if ({credits, payout, win} !== {8'd14, 8'd2, 1'b1}) begin failures++; $display("FAIL pair_coin credits=%0d payout=%0d win=%b exp 14/2/1", credits, payout, win); end
  endtask

  task automatic test_no_win();
    do_spin();
    stop_with(4'd1);
    stop_with(4'd2);
    stop_with(4'd3);
    checks++; if (win !== 1'b0) begin failures++; $display("FAIL nowin_eval win=%b exp=0", win); end
    tick();
    checks++; if ({credits, payout, win} !== {8'd13, 8'd0, 1'b0}) begin failures++; $display("FAIL nowin credits=%0d payout=%0d win=%b exp 13/0/0", credits, payout, win); end
    stop_with(4'd7);
    checks++; if ({held0, reel_run, win, busy} !== {4'd1, 3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL stop_idle held0=%0d run=%b win=%b busy=%b exp 1/000/0/0", held0, reel_run, win, busy); end
  endtask

  task automatic test_no_credit();
    do_reset();
    do_spin();
    checks++; if ({credits, reel_run, busy} !== {8'd0, 3'b000, 1'b0}) begin failures++; $display("FAIL zero_spin credits=%0d run=%b busy=%b exp 0/000/0", credits, reel_run, busy); end
    coin = 1'b1; spin_btn = 1'b1;
    tick();
    coin = 1'b0; spin_btn = 1'b0;
    checks++; if ({credits, reel_run, busy} !== {8'd1, 3'b000, 1'b0}) begin failures++; $display("FAIL coin_spin0 credits=%0d run=%b busy=%b exp 1/000/0", credits, reel_run, busy); end
  endtask

  task automatic test_saturate();
    do_reset();
    coin = 1'b1;
    repeat (256) tick();
    checks++; if (credits !== 8'd255) begin failures++; $display("FAIL coin_sat got=%0d exp=255", credits); end
    spin_btn = 1'b1;
    tick();
    coin = 1'b0; spin_btn = 1'b0;
    checks++; if ({credits, busy} !== {8'd255, 1'b1}) begin failures++; $display("FAIL coin_spin_max credits=%0d busy=%b exp 255/1", credits, busy); end
    stop_with(4'd1);
    stop_with(4'd2);
    stop_with(4'd3);
    tick();
    do_reset();
    coin = 1'b1;
    repeat (251) tick();
    coin = 1'b0;
    do_spin();
    checks++; if (credits !== 8'd250) begin failures++; $display("FAIL pre_sat got=%0d exp=250", credits); end
    stop_with(4'd5);
    stop_with(4'd5);
    stop_with(4'd5);
    tick();
    checks++; if ({credits, payout, win} !== {8'd255, 8'd10, 1'b1}) begin failures++; $display("FAIL payout_sat credits=%0d payout=%0d win=%b exp 255/10/1", credits, payout, win); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    coin = 1'b1;
    repeat (2) tick();
    coin = 1'b0;
    do_spin();
    stop_with(4'd7);
    checks++; if ({credits, held0, reel_run} !== {8'd1, 4'd7, 3'b110}) begin failures++; $display("FAIL mid_pre credits=%0d held0=%0d run=%b exp 1/7/110", credits, held0, reel_run); end
    do_reset();
    checks++; if ({credits, reel_run, held0, held1, held2} !== {8'd0, 3'b000, 12'h444}) begin failures++; $display("FAIL mid_reset credits=%0d run=%b held=%h exp 0/000/444", credits, reel_run, {held0, held1, held2}); end
    checks++; if ({payout, win, busy} !== 10'd0) begin failures++; $display("FAIL mid_reset_out payout=%0d win=%b busy=%b exp 0/0/0", payout, win, busy); end
    do_spin();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    coin = 1'b1; tick(); coin = 1'b0;
    do_spin();
`ifdef SLOT_AUTO_STOP_EN
    for (int k = 0; k < 3; k++) begin
      int n;
      logic [2:0] prev;
      n = 0;
      prev = reel_run;
      while (reel_run === prev && n < 200) begin
        tick();
        n++;
      end
      checks++; if (n !== 64) begin failures++; $display("FAIL auto_stop%0d cycles=%0d exp=64", k, n); end
    end
    checks++; if ({reel_run, busy} !== {3'b000, 1'b1}) begin failures++; $display("FAIL auto_eval run=%b busy=%b exp 000/1", reel_run, busy); end
    tick();
    checks++; if ({busy, credits, payout} !== {1'b0, 8'd10, 8'd10}) begin failures++; $display("FAIL auto_done busy=%b credits=%0d payout=%0d exp 0/10/10", busy, credits, payout); end
`else
    repeat (100) tick();
    checks++; if ({reel_run, busy} !== {3'b111, 1'b1}) begin failures++; $display("FAIL no_auto run=%b busy=%b exp 111/1", reel_run, busy); end
    stop_with(4'd1);
    stop_with(4'd2);
    stop_with(4'd3);
    tick();
    checks++; if ({busy, credits} !== {1'b0, 8'd0}) begin failures++; $display("FAIL no_auto_done busy=%b credits=%0d exp 0/0", busy, credits); end
`endif
  endtask

  initial begin
    test_reset();
    test_triple();
    test_back_to_back();
    test_no_win();
    test_no_credit();
    test_saturate();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
